// File: rtl/seg_pkg.sv
// Shared types for the seven-segment scan controller: segment vectors and digit slots.
package seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic       valid;
    logic [3:0] val;
  } digit_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Active-low hex to seven-segment decoder, bit order {g,f,e,d,c,b,a}.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multi-digit seven-segment controller: strobed digit entry into a shift register,
// static per-digit decode, and a time-multiplexed anode/segment scan with cursor blink.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [3:0]                        DispVal,
  input  logic                              updated,
  input  logic                              clear,
  input  logic                              blink_en,
  output logic [6:0]                        segOut,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [7*NUM_DIGITS-1:0]           out_seg,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);

  digit_t                  digits_q [NUM_DIGITS];
  digit_t                  digits_d [NUM_DIGITS];
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    updated_q;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    shift;
  logic                    tick;
  digit_t                  sel_digit;
  logic [6:0]              scan_dec;

  always_comb begin
    shift    = updated && !updated_q;
    count_d  = count_q;
    for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = digits_q[i];

    // Clear takes priority and swallows a coincident strobe edge.
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits_d[i].valid = 1'b0;
      count_d = '0;
    end else if (shift) begin
      for (int i = 1; i < NUM_DIGITS; i++) digits_d[i] = digits_q[i-1];
      digits_d[0] = '{valid: 1'b1, val: DispVal};
      if (count_q != CNT_W'(NUM_DIGITS)) count_d = count_q + 1'b1;
    end
  end

  always_comb begin
    tick        = (div_q == DIV_W'(REFRESH_DIV - 1));
    div_d       = tick ? '0 : div_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  assign sel_digit = digits_q[idx_q];

  hex_to_seg7 u_scan_dec (
    .hex_i (sel_digit.val),
    .seg_o (scan_dec)
  );

  // Cursor blink only ever blanks the scanned drive, never the static bus.
  always_comb begin
    seg_d = scan_dec;
    if (!sel_digit.valid || (blink_en && phase_q && idx_q == '0)) seg_d = SEG_BLANK;
    an_d = ~(NUM_DIGITS'(1) << idx_q);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_static
      logic [6:0] dec;
      hex_to_seg7 u_dec (
        .hex_i (digits_q[gi].val),
        .seg_o (dec)
      );
      assign out_seg[7*gi +: 7] = digits_q[gi].valid ? dec : SEG_BLANK;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= '0;
      count_q     <= '0;
      updated_q   <= 1'b1;
      div_q       <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= digits_d[i];
      count_q     <= count_d;
      updated_q   <= updated;
      div_q       <= div_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign segOut = seg_q;
  assign an     = an_q;
  assign count  = count_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: entry, saturation, clear priority, scan, blink, async reset.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  DispVal;
  logic        updated, clear, blink_en;
  logic [6:0]  segOut, segOut_b;
  logic [3:0]  an, an_b;
  logic [27:0] out_seg, out_seg_b;
  logic [2:0]  count, count_b;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int mdig [4];

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .DispVal(DispVal), .updated(updated), .clear(clear),
    .blink_en(blink_en), .segOut(segOut), .an(an), .out_seg(out_seg), .count(count)
  );

  // Slower blink so the cursor visibly alternates between index-0 windows.
  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLINK_DIV(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .DispVal(DispVal), .updated(updated), .clear(clear),
    .blink_en(blink_en), .segOut(segOut_b), .an(an_b), .out_seg(out_seg_b), .count(count_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [3:0] v, input int hi, input int lo);
    DispVal = v;
    updated = 1'b1;
    repeat (hi) @(negedge clk);
    updated = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Sample e edges after reset release: scan state before edge e drives the outputs.
  task automatic scan_check(input int n);
    int e, t, idx;
    logic [6:0] base, ea, eb;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e    = cyc;
      t    = (e - 1) / 4;
      idx  = t % 4;
      base = (mdig[idx] < 0) ? 7'h7F : seg_tab[mdig[idx]];
      ea   = (blink_en && ((t / 2) % 2 == 1) && idx == 0) ? 7'h7F : base;
      eb   = (blink_en && ((t / 8) % 2 == 1) && idx == 0) ? 7'h7F : base;
      chk("scan_an", {28'd0, an}, (~(32'd1 << idx)) & 32'hF);
      chk("scan_seg", {25'd0, segOut}, {25'd0, ea});
      chk("scan_an_b", {28'd0, an_b}, (~(32'd1 << idx)) & 32'hF);
      chk("blink8_seg", {25'd0, segOut_b}, {25'd0, eb});
    end
  endtask

  initial begin
    logic found;
    rst_n = 1'b0; DispVal = 4'h0; updated = 1'b0; clear = 1'b0; blink_en = 1'b0;
    for (int i = 0; i < 4; i++) mdig[i] = -1;

    repeat (2) @(negedge clk);
    chk("rst_out_seg", {4'd0, out_seg}, 32'h0FFFFFFF);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, segOut}, 32'h7F);

    rst_n = 1'b1;
    scan_check(16);
    chk("idle_out_seg", {4'd0, out_seg}, 32'h0FFFFFFF);
    chk("idle_count", {29'd0, count}, 32'd0);

    strobe(4'h1, 5, 5);
    strobe(4'h2, 5, 5);
    strobe(4'h3, 5, 5);
    chk("e123_out_seg", {4'd0, out_seg}, {4'd0, 7'h7F, 7'h79, 7'h24, 7'h30});
    chk("e123_count", {29'd0, count}, 32'd3);
    mdig[0] = 3; mdig[1] = 2; mdig[2] = 1; mdig[3] = -1;
    scan_check(16);

    for (int v = 0; v < 6; v++) strobe(4'(v), 2, 2);
    chk("e05_out_seg", {4'd0, out_seg}, {4'd0, 7'h24, 7'h30, 7'h19, 7'h12});
    chk("e05_count", {29'd0, count}, 32'd4);

    DispVal = 4'h6; updated = 1'b1;
    @(negedge clk);
    chk("hold_first", {4'd0, out_seg}, {4'd0, 7'h30, 7'h19, 7'h12, 7'h02});
    repeat (19) @(negedge clk);
    chk("hold_end", {4'd0, out_seg}, {4'd0, 7'h30, 7'h19, 7'h12, 7'h02});
    chk("hold_count", {29'd0, count}, 32'd4);
    updated = 1'b0;
    repeat (3) @(negedge clk);

    clear = 1'b1; updated = 1'b1; DispVal = 4'h7;
    @(negedge clk);
    chk("clr_out_seg", {4'd0, out_seg}, 32'h0FFFFFFF);
    chk("clr_count", {29'd0, count}, 32'd0);
    clear = 1'b0;
    repeat (5) @(negedge clk);
    chk("clr_hold_out_seg", {4'd0, out_seg}, 32'h0FFFFFFF);
    chk("clr_hold_count", {29'd0, count}, 32'd0);
    updated = 1'b0;
    repeat (2) @(negedge clk);

    strobe(4'h8, 3, 3);
    strobe(4'h9, 3, 3);
    strobe(4'hA, 3, 3);
    strobe(4'hB, 3, 3);
    mdig[0] = 11; mdig[1] = 10; mdig[2] = 9; mdig[3] = 8;
    chk("blk_count", {29'd0, count}, 32'd4);
    chk("blk_count_b", {29'd0, count_b}, 32'd4);
    blink_en = 1'b1;
    scan_check(128);
    chk("blk_out_seg", {4'd0, out_seg}, {4'd0, 7'h00, 7'h10, 7'h08, 7'h03});
    chk("blk_out_seg_b", {4'd0, out_seg_b}, {4'd0, 7'h00, 7'h10, 7'h08, 7'h03});
    blink_en = 1'b0;

    found = 1'b0;
    for (int k = 0; k < 32 && !found; k++) begin
      @(negedge clk);
      if (an === 4'b1011) found = 1'b1;
    end
    chk("reach_idx2", {31'd0, found}, 32'd1);
    updated = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", {28'd0, an}, 32'hF);
    chk("arst_seg", {25'd0, segOut}, 32'h7F);
    chk("arst_out_seg", {4'd0, out_seg}, 32'h0FFFFFFF);
    chk("arst_count", {29'd0, count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mdig[i] = -1;
    scan_check(8);
    chk("rel_no_shift", {29'd0, count}, 32'd0);
    updated = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
